// File: rtl/registrador_historico_n.sv
// History bank of the last DEPTH N-bit pushes (newest at 0) with random read, count and full/empty/overflow flags.
// Latency: a push is visible one cycle later; Q/ultimo/flags decode registered state only; compare result 1 cycle after compara.
// Backpressure: none, pushes are always accepted and the oldest entry drops when full; REGISTRADOR_HISTORICO_COMPARE_EN adds the compare port.
module registrador_historico_n #(
    parameter int N     = 4,
    parameter int DEPTH = 8,
    parameter int A     = 3
) (
    input  logic         clock,
    input  logic         clear_n,
    input  logic         zera,
    input  logic         push,
    input  logic [N-1:0] D,
    input  logic [A-1:0] rd_addr,
    output logic [N-1:0] Q,
    output logic [N-1:0] ultimo,
    output logic [A:0]   count,
    output logic         vazio,
    output logic         cheio,
    output logic         overflow,
    input  logic         compara,
    output logic         igual,
    output logic         igual_valid
);

    localparam logic [A:0] DEPTH_C = (A+1)'(DEPTH);

    logic [N-1:0] entry_q [DEPTH];
    logic [N-1:0] entry_d [DEPTH];
    logic [A:0]   count_q, count_d;
    logic         overflow_q, overflow_d;
    logic         rd_hit;
    logic [N-1:0] rd_dat;

    // Entries at or beyond count read as zero, which also covers rd_addr >= DEPTH.
    always_comb begin
        rd_hit = 1'b0;
        rd_dat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, rd_addr} == (A+1)'(i)) && ((A+1)'(i) < count_q)) begin
                rd_hit = 1'b1;
                rd_dat = entry_q[i];
            end
        end
    end

    assign Q        = rd_dat;
    assign ultimo   = (count_q != '0) ? entry_q[0] : '0;
    assign count    = count_q;
    assign vazio    = (count_q == '0);
    assign cheio    = (count_q == DEPTH_C);
    assign overflow = overflow_q;

    always_comb begin
        entry_d    = entry_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (zera) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i] = '0;
            end
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                entry_d[i] = entry_q[i-1];
            end
            entry_d[0] = D;
            if (count_q == DEPTH_C) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + (A+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            entry_q    <= entry_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef REGISTRADOR_HISTORICO_COMPARE_EN
    logic igual_q, igual_d;
    logic igual_valid_q, igual_valid_d;

    // Compares against the pre-push contents, so a same-edge push does not affect the result.
    always_comb begin
        igual_d       = igual_q;
        igual_valid_d = 1'b0;
        if (zera) begin
            igual_d = 1'b0;
        end else if (compara) begin
            igual_d       = rd_hit && (D == rd_dat);
            igual_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            igual_q       <= 1'b0;
            igual_valid_q <= 1'b0;
        end else begin
            igual_q       <= igual_d;
            igual_valid_q <= igual_valid_d;
        end
    end

    assign igual       = igual_q;
    assign igual_valid = igual_valid_q;
`else
    logic compara_unused;
    assign compara_unused = compara;
    assign igual          = 1'b0;
    assign igual_valid    = 1'b0;
`endif

endmodule

// File: doc/registrador_historico_n.md
# registrador_historico_N

Parametrised history register bank: keeps the last DEPTH values of width N pushed into it, newest at index 0, with random-access read, occupancy count and full/empty/overflow flags. Used in PULO DO SAPO to store the sequence of frog moves for replay and checking. Optionally compares an incoming value against a stored entry. Successor to the single-word enable register: same write-on-enable semantics, generalised to DEPTH entries with shift-in history.

## Interface

- N, 4, data width in bits (N >= 1)
- DEPTH, 8, number of entries (DEPTH >= 1)
- A, 3, address width; must satisfy 2^A >= DEPTH

- clock  in  1  rising-edge clock; only clock in the block
- clear_n  in  1  reset, synchronous, active-low; sampled on the clock rising edge
- zera  in  1  soft clear, synchronous, active-high
- push  in  1  shift D into entry 0 on this edge
- D  in  N  data to push (and compare operand)
- rd_addr  in  A  read index, 0 = newest
- Q  out  N  entry[rd_addr]; 0 when rd_addr >= count
- ultimo  out  N  entry[0]; 0 when empty
- count  out  A+1  valid entries, 0..DEPTH
- vazio  out  1  count == 0
- cheio  out  1  count == DEPTH
- overflow  out  1  sticky: a push was made while full
- compara  in  1  compare strobe (feature-dependent)
- igual  out  1  registered compare result (feature-dependent)
- igual_valid  out  1  one-cycle pulse qualifying igual (feature-dependent)

## Operation

- Storage: DEPTH registers entry[0..DEPTH-1], each N bits, plus count and overflow registers.
- Priority per rising edge: clear_n low > zera high > push/compara.
- clear_n low: all entries 0, count 0, overflow 0, igual 0, igual_valid 0.
- zera high (clear_n high): same effect as clear_n; push and compara that cycle are dropped.
- push, not full: entry[i] <= entry[i-1] for i >= 1, entry[0] <= D, count <= count+1.
- push, full: same shift, oldest (entry[DEPTH-1]) discarded, count stays DEPTH, overflow <= 1.
- overflow stays 1 until clear_n or zera.
- No push: storage, count, overflow hold.
- Q, ultimo, vazio, cheio: combinational decode of registered state; no combinational path from D or push to any output.
- rd_addr >= count (including rd_addr >= DEPTH): Q = 0.
- DEPTH = 1: every push after the first sets overflow; entry[0] always holds the last pushed value.

## Timing

- Reset values: Q 0, ultimo 0, count 0, vazio 1, cheio 0, overflow 0, igual 0, igual_valid 0.
- Push latency: 1 cycle; value visible on ultimo and at Q[rd_addr=0] after the edge that samples push.
- Back-to-back pushes every cycle supported; count saturates at DEPTH.
- Q follows rd_addr combinationally within the same cycle.
- Compare (when enabled): sampled on the same edge as push using pre-push contents; igual/igual_valid valid the cycle after compara.
- Mid-operation reset: clear_n low on any edge wipes state regardless of push/compara.

## Configuration

- Macro: REGISTRADOR_HISTORICO_COMPARE_EN.
- Defined: on an edge with compara high (no clear/zera), igual <= (rd_addr < count) && (D == entry[rd_addr]), igual_valid <= 1; otherwise igual_valid <= 0 and igual holds.
- Not defined: compare logic absent, compara ignored, igual and igual_valid tied to 0.

## Test plan

- N=4, DEPTH=4: release clear_n, push 1,2,3 -> count 3, ultimo 3, Q@rd_addr=2 = 1, Q@rd_addr=3 = 0, vazio 0, cheio 0, overflow 0.
- Continue push 4, 5 -> after 4: cheio 1, count 4; after 5: entries 5,4,3,2, overflow 1, count 4.
- zera high together with push of 9 -> count 0, vazio 1, overflow 0, ultimo 0; 9 not stored.
- clear_n low mid-burst of pushes (push held high) -> next cycle all outputs at reset values; pushes resume cleanly after release.
- Macro defined, entries 3,2,1: rd_addr=1, D=2, compara=1 -> next cycle igual 1, igual_valid 1; D=7 -> igual 0; rd_addr=3 -> igual 0; compara and push same cycle compares pre-push entry.
- Macro undefined: compara toggled with matching data -> igual and igual_valid remain 0.
